ktop_counter_bank: RTL



---
 rtl/ktop_counter_pkg.sv | 30 +++
 rtl/ktop_counter_lane.sv | 93 +++++++++
 rtl/ktop_counter_bank.sv | 50 +++++
 3 files changed

// File: rtl/ktop_counter_pkg.sv
// rtl/ktop_counter_pkg.sv - shared types and op decode for the ktop counter bank
package ktop_counter_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_LOAD,
        CNT_UP,
        CNT_DOWN
    } cnt_op_t;

    // Load wins over counting; incr and decr together cancel to a hold.
    function automatic cnt_op_t cnt_decode(
        input logic load,
        input logic incr,
        input logic decr
    );
        cnt_op_t op;
        if (load) begin
            op = CNT_LOAD;
        end else if (incr && !decr) begin
            op = CNT_UP;
        end else if (!incr && decr) begin
            op = CNT_DOWN;
        end else begin
            op = CNT_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/ktop_counter_lane.sv
// rtl/ktop_counter_lane.sv - one up/down counter channel with registered flags and overflow event
module ktop_counter_lane
    import ktop_counter_pkg::*;
#(
    parameter int                 C_WIDTH      = 16,
    parameter int                 C_STEP_WIDTH = 4,
    parameter int                 C_SATURATE   = 0,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clken,
    input  logic                    load,
    input  logic                    incr,
    input  logic                    decr,
    input  logic [C_STEP_WIDTH-1:0] step,
    input  logic [C_WIDTH-1:0]      load_value,
    output logic [C_WIDTH-1:0]      count,
    output logic                    is_zero,
    output logic                    is_max,
    output logic                    ovf
);

    localparam logic [C_WIDTH-1:0] MAX_VAL = {C_WIDTH{1'b1}};

    logic [C_WIDTH-1:0] count_q, count_d;
    logic               is_zero_q, is_zero_d;
    logic               is_max_q, is_max_d;
    logic               ovf_q, ovf_d;
    logic [C_WIDTH:0]   step_ext;
    logic [C_WIDTH:0]   sum;
    logic [C_WIDTH:0]   diff;
    cnt_op_t            op;

    // Next count: one extra bit on add/sub exposes carry/borrow for wrap or clamp.
    always_comb begin
        op       = cnt_decode(load, incr, decr);
        step_ext = {{(C_WIDTH + 1 - C_STEP_WIDTH){1'b0}}, step};
        sum      = {1'b0, count_q} + step_ext;
        diff     = {1'b0, count_q} - step_ext;
        count_d  = count_q;
        ovf_d    = 1'b0;
        if (clken) begin
            case (op)
                CNT_LOAD: begin
                    count_d = load_value;
                end
                CNT_UP: begin
                    if (sum[C_WIDTH]) begin
                        count_d = (C_SATURATE != 0) ? MAX_VAL : sum[C_WIDTH-1:0];
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = sum[C_WIDTH-1:0];
                    end
                end
                CNT_DOWN: begin
                    if (diff[C_WIDTH]) begin
                        count_d = (C_SATURATE != 0) ? '0 : diff[C_WIDTH-1:0];
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = diff[C_WIDTH-1:0];
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        is_zero_d = (count_d == '0);
        is_max_d  = (count_d == MAX_VAL);
    end

    // Count and flags register together so flags always describe the visible count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= C_INIT;
            is_zero_q <= (C_INIT == '0);
            is_max_q  <= (C_INIT == MAX_VAL);
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            is_zero_q <= is_zero_d;
            is_max_q  <= is_max_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count   = count_q;
    assign is_zero = is_zero_q;
    assign is_max  = is_max_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/ktop_counter_bank.sv
// rtl/ktop_counter_bank.sv - bank of independent up/down counters with packed per-channel buses
module ktop_counter_bank
    import ktop_counter_pkg::*;
#(
    parameter int                 C_WIDTH      = 16,
    parameter int                 C_CHANNELS   = 4,
    parameter int                 C_STEP_WIDTH = 4,
    parameter int                 C_SATURATE   = 0,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clken,
    input  logic [C_CHANNELS-1:0]              load,
    input  logic [C_CHANNELS-1:0]              incr,
    input  logic [C_CHANNELS-1:0]              decr,
    input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
    input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
    output logic [C_CHANNELS*C_WIDTH-1:0]      count,
    output logic [C_CHANNELS-1:0]              is_zero,
    output logic [C_CHANNELS-1:0]              is_max,
    output logic [C_CHANNELS-1:0]              ovf,
    output logic                               all_zero
);

    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_lane
        ktop_counter_lane #(
            .C_WIDTH      (C_WIDTH),
            .C_STEP_WIDTH (C_STEP_WIDTH),
            .C_SATURATE   (C_SATURATE),
            .C_INIT       (C_INIT)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clken      (clken),
            .load       (load[i]),
            .incr       (incr[i]),
            .decr       (decr[i]),
            .step       (step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
            .load_value (load_value[i*C_WIDTH +: C_WIDTH]),
            .count      (count[i*C_WIDTH +: C_WIDTH]),
            .is_zero    (is_zero[i]),
            .is_max     (is_max[i]),
            .ovf        (ovf[i])
        );
    end

    assign all_zero = &is_zero;

endmodule
